v_id_stage: RTL and testbench
=============================

// Module: v_id_stage
// PURPOSE
//  Decode stage feeding the ALU: accepts RV32I instruction words, decodes ALU-class ops
//  (R-type, OP-IMM, LUI) into {A, B, alu_op}, reads the internal 32x32 register file and
//  presents operands to EX through a one-entry valid/ready pipeline register. Also owns
//  the regfile write port used by writeback. Producer side of the ALU operand/op interface.
// PARAMETERS
//  XLEN      32  datapath width (only 32 supported)
//  NREGS     32  register count; x0 hardwired zero
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   asynchronous, active-high reset
//  in_valid    in   1   instr holds a valid instruction
//  in_ready    out  1   stage can accept instr this cycle
//  instr       in   32  RV32I instruction word
//  wb_en       in   1   writeback enable
//  wb_rd       in   5   writeback destination
//  wb_data     in   32  writeback data
//  out_valid   out  1   EX-side payload valid
//  out_ready   in   1   EX accepts payload this cycle
//  op_a        out  32  ALU operand A
//  op_b        out  32  ALU operand B
//  alu_op      out  4   ADD=0 SUB=1 XOR=2 OR=3 AND=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9
//  rd          out  5   destination register
//  reg_write   out  1   result must be written back
//  illegal     out  1   instruction not decodable by this stage
// BEHAVIOUR
//  - Reset (async): out_valid=0; op_a/op_b/rd=0; alu_op=0; reg_write=0; illegal=0; all regs=0.
//  - in_ready = ~out_valid | out_ready (combinational). Accept when in_valid & in_ready.
//  - Latency 1: accepted instr appears on outputs next cycle with out_valid=1.
//  - Output register holds stable while out_valid & ~out_ready; cleared (out_valid=0)
//    on out_ready when no new accept in same cycle; accept+drain same cycle -> back-to-back.
//  - Opcode 0110011 (R): A=x[rs1], B=x[rs2]. funct3 000:ADD/SUB(f7=0100000), 001:SLL,
//    010:SLT, 011:SLTU, 100:XOR, 101:SRL/SRA(f7=0100000), 110:OR, 111:AND.
//    funct7 must be 0000000, or 0100000 only with funct3 000/101; else illegal.
//  - Opcode 0010011 (I): A=x[rs1], B=sext(instr[31:20]); same funct3 map, no SUB.
//    SLLI requires f7=0000000; SRLI/SRAI select on f7 0000000/0100000; other f7 illegal.
//  - Opcode 0110111 (LUI): A=0, B={instr[31:12],12'b0}, alu_op=ADD.
//  - Any other opcode or illegal encoding: out_valid=1, illegal=1, reg_write=0,
//    alu_op=ADD, op_a=op_b=0. Stage never blocks on illegal.
//  - reg_write=1 for legal decodes with rd!=0; rd=0 forces reg_write=0.
//  - Regfile: write at posedge when wb_en & wb_rd!=0; writes to x0 ignored; x0 reads 0.
//  - Write-through bypass: read of register being written same cycle returns wb_data.
//  - Operands captured at accept; later writeback does not alter a held payload.
//  - No RAW hazard detection/forwarding from EX/MEM here; handled upstream (stall on in_valid).
//  - Reset mid-transfer: held payload discarded, out_valid drops immediately.
// TESTING
//  1 Reset: rst=1 any time -> out_valid=0, in_ready=1, all regs read 0.
//  2 wb x1=5, x2=3; instr SUB x3,x1,x2 (0x402081B3) -> next cycle op_a=5 op_b=3 alu_op=1 rd=3 reg_write=1.
//  3 ADDI x4,x0,-1 (0xFFF00213) -> op_a=0, op_b=0xFFFFFFFF, alu_op=0; SRAI x5,x1,4 (0x4040D293) -> op_b=4, alu_op=7.
//  4 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, payload unchanged; release -> next instr follows back-to-back.
//  5 wb_en x6=0xA5 same cycle as accept of OR x7,x6,x0 -> op_a=0xA5 (bypass); wb x0=7 -> x0 still reads 0.
//  6 instr 0x0000007F or SLLI with f7=0100000 -> illegal=1, reg_write=0, out_valid=1; LUI x8,0x12345 -> op_b=0x12345000.

Source files
------------

// File: rtl/v_id_stage.sv
// RV32I decode stage for ALU-class ops (R-type, OP-IMM, LUI) with an internal 32x32
// register file and a one-entry valid/ready output register toward EX.
module v_id_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [3:0]      alu_op,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            illegal
);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] shamt;
    logic [3:0]      base_op;

    logic [XLEN-1:0] d_a;
    logic [XLEN-1:0] d_b;
    logic [3:0]      d_op;
    logic [4:0]      d_rd;
    logic            d_rw;
    logic            d_ill;
    logic            accept;

    // Handshake: a transfer happens on any cycle where valid and ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

    // Reads see a same-cycle writeback so a writer and reader can pass in one cycle.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) rs1_val = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
        if (rs2 != 5'd0) rs2_val = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
    end

    always_comb begin
        base_op = ALU_ADD;
        case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    end

    always_comb begin
        d_a   = '0;
        d_b   = '0;
        d_op  = ALU_ADD;
        d_ill = 1'b1;
        case (opcode)
            OPC_R: begin
                if (funct7 == F7_ZERO ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    d_ill = 1'b0;
                    d_a   = rs1_val;
                    d_b   = rs2_val;
                    d_op  = base_op;
                    if (funct7 == F7_ALT) d_op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end
            end
            OPC_I: begin
                if (funct3 == 3'b001) begin
                    if (funct7 == F7_ZERO) begin
                        d_ill = 1'b0;
                        d_a   = rs1_val;
                        d_b   = shamt;
                        d_op  = ALU_SLL;
                    end
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ZERO || funct7 == F7_ALT) begin
                        d_ill = 1'b0;
                        d_a   = rs1_val;
                        d_b   = shamt;
                        d_op  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                end else begin
                    d_ill = 1'b0;
                    d_a   = rs1_val;
                    d_b   = imm_i;
                    d_op  = base_op;
                end
            end
            OPC_LUI: begin
                d_ill = 1'b0;
                d_b   = {instr[31:12], 12'b0};
            end
            default: d_ill = 1'b1;
        endcase
        // Illegal payloads carry rd=0 so nothing downstream can mistake them for a write.
        d_rd = d_ill ? 5'd0 : instr[11:7];
        d_rw = ~d_ill & (instr[11:7] != 5'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            alu_op    <= ALU_ADD;
            rd        <= 5'd0;
            reg_write <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            op_a      <= d_a;
            op_b      <= d_b;
            alu_op    <= d_op;
            rd        <= d_rd;
            reg_write <= d_rw;
            illegal   <= d_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_v_id_stage.sv
// Bench for v_id_stage: directed scenarios plus random traffic, all checked against
// an instruction-level reference model and an expected-payload queue.
module tb_v_id_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;

    v_id_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .rd(rd),
        .reg_write(reg_write), .illegal(illegal)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    localparam int PW = 75;
    logic [PW-1:0] exp_q[$];
    logic [31:0]   regs_m[32];
    int            total;
    int            bad;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] read_m(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_rd == idx) return wb_data;
        return regs_m[idx];
    endfunction

    // Reference decode: {op_a, op_b, alu_op, rd, reg_write, illegal}
    function automatic logic [PW-1:0] ref_decode(input logic [31:0] ins);
        logic [3:0]  f3_map[8];
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [31:0] a, b, imm;
        logic [3:0]  op;
        logic        ill, rw;
        logic [4:0]  dst;
        f3_map = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        imm = {{20{ins[31]}}, ins[31:20]};
        ill = 1'b1; a = 0; b = 0; op = 0;
        if (opc == 7'h33) begin
            if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                ill = 0; a = read_m(ins[19:15]); b = read_m(ins[24:20]);
                op = f3_map[f3] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
            end
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                if (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5)) begin
                    ill = 0; a = read_m(ins[19:15]); b = 32'(ins[24:20]);
                    op = f3_map[f3] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
                end
            end else begin
                ill = 0; a = read_m(ins[19:15]); b = imm; op = f3_map[f3];
            end
        end else if (opc == 7'h37) begin
            ill = 0; b = ins[31:12] << 12;
        end
        dst = ill ? 5'd0 : ins[11:7];
        rw  = !ill && dst != 0;
        return {a, b, op, dst, rw, ill};
    endfunction

    task automatic check_out();
        check("out_valid", PW'(out_valid), PW'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            check("payload", {op_a, op_b, alu_op, rd, reg_write, illegal}, exp_q[0]);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; drives one cycle, updates the model, checks the result.
    task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        logic exp_rdy;
        in_valid = iv; instr = ins; out_ready = ordy;
        wb_en = we; wb_rd = wrd; wb_data = wd;
        #1;
        exp_rdy = (exp_q.size() == 0) || ordy;
        check("in_ready", PW'(in_ready), PW'(exp_rdy));
        if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
        if (iv && exp_rdy) exp_q.push_back(ref_decode(ins));
        if (we && wrd != 5'd0) regs_m[wrd] = wd;
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  f7;
        logic [4:0]  d, s1, s2;
        logic [2:0]  f3;
        int          sel;
        r   = $urandom;
        f3  = 3'($urandom_range(0, 7));
        d   = 5'($urandom_range(0, 7));
        s1  = 5'($urandom_range(0, 7));
        s2  = 5'($urandom_range(0, 7));
        sel = $urandom_range(0, 3);
        f7  = (sel == 0 || sel == 1) ? 7'h00 : (sel == 2) ? 7'h20 : r[31:25];
        sel = $urandom_range(0, 9);
        if (sel <= 3)      return {f7, s2, s1, f3, d, 7'h33};
        else if (sel <= 6) return {f7, r[24:20], s1, f3, d, 7'h13};
        else if (sel == 7) return {r[19:0], d, 7'h37};
        return r;
    endfunction

    // ---------------- stimulus ----------------
    logic [PW-1:0] held;

    initial begin
        total = 0; bad = 0;
        model_reset();
        rst = 1'b1; in_valid = 0; instr = 0; out_ready = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", PW'(out_valid), PW'(0));
        check("rst_in_ready", PW'(in_ready), PW'(1));
        check("rst_payload", {op_a, op_b, alu_op, rd, reg_write, illegal}, PW'(0));
        rst = 1'b0;

        // Registers read zero after reset
        step(1, 32'h00208633, 1, 0, 0, 0);
        check("rst_regs", PW'({op_a, op_b}), PW'(0));

        // SUB x3,x1,x2
        step(0, 0, 1, 1, 5'd1, 32'd5);
        step(0, 0, 1, 1, 5'd2, 32'd3);
        step(1, 32'h402081B3, 1, 0, 0, 0);
        check("sub_a", PW'(op_a), PW'(5));
        check("sub_b", PW'(op_b), PW'(3));
        check("sub_op", PW'(alu_op), PW'(1));
        check("sub_rd_rw", PW'({rd, reg_write}), PW'({5'd3, 1'b1}));

        // ADDI x4,x0,-1 then SRAI x5,x1,4
        step(1, 32'hFFF00213, 1, 0, 0, 0);
        check("addi_b", PW'({op_a, op_b, alu_op}), PW'({32'd0, 32'hFFFFFFFF, 4'd0}));
        step(1, 32'h4040D293, 1, 0, 0, 0);
        check("srai", PW'({op_b, alu_op}), PW'({32'd4, 4'd7}));

        // Backpressure: hold 3 cycles, then back-to-back
        step(1, 32'h002084B3, 0, 0, 0, 0);
        held = {op_a, op_b, alu_op, rd, reg_write, illegal};
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h0020C533, 0, 1, 5'd1, 32'd99);
            check("bp_hold", {op_a, op_b, alu_op, rd, reg_write, illegal}, held);
        end
        step(1, 32'h0020C533, 1, 0, 0, 0);
        check("bp_next", PW'({out_valid, op_a, alu_op, rd}), PW'({1'b1, 32'd99, 4'd2, 5'd10}));

        // Bypass and x0 writes
        step(1, 32'h000363B3, 1, 1, 5'd6, 32'hA5);
        check("bypass", PW'(op_a), PW'(32'hA5));
        step(0, 0, 1, 1, 5'd0, 32'd7);
        step(1, 32'h000005B3, 1, 0, 0, 0);
        check("x0_zero", PW'({op_a, op_b}), PW'(0));

        // Illegal encodings and LUI
        step(1, 32'h0000007F, 1, 0, 0, 0);
        check("ill_opc", PW'({out_valid, illegal, reg_write}), PW'(3'b110));
        step(1, 32'h40109293, 1, 0, 0, 0);
        check("ill_slli", PW'({out_valid, illegal, reg_write}), PW'(3'b110));
        step(1, 32'h12345437, 1, 0, 0, 0);
        check("lui", PW'({op_a, op_b, rd}), PW'({32'd0, 32'h12345000, 5'd8}));

        // Reset while a payload is held
        step(1, 32'h002084B3, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", PW'(out_valid), PW'(0));
        check("rst_mid_ready", PW'(in_ready), PW'(1));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1, 32'h00208633, 1, 0, 0, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
